// File: rtl/sh7604_ibus_master_pkg.sv
// sh7604_ibus_master_pkg
//   Shared types and constants for the SH7604 on-chip peripheral bus (IBUS)
//   initiator and its lane helper (also reused by the DMAC).
//   - IBUS_SZ_t       : access size encoding as presented by the CPU/DMAC
//   - IBusState_t     : initiator FSM states
//   - IBUS_REGION_BASE: base of the 512-byte peripheral window FFFFFE00-FFFFFFFF
package sh7604_ibus_master_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_W = 2'b01,
    SZ_L = 2'b10
  } IBUS_SZ_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } IBusState_t;

  localparam logic [31:0] IBUS_REGION_BASE = 32'hFFFF_FE00;

  // The window is 512 bytes, so only A[31:9] decide membership.
  function automatic logic ibus_in_region(input logic [31:0] a);
    return a[31:9] == IBUS_REGION_BASE[31:9];
  endfunction

endpackage

// File: rtl/sh7604_ibus_lane.sv
// sh7604_ibus_lane
//   Combinational byte-lane helper for the big-endian IBUS.
//   Ports:
//     sz      in  2   access size (SZ_B/SZ_W/SZ_L, 11 behaves as long)
//     a_lo    in  2   address bits [1:0]
//     wd      in  32  right-justified write data
//     rd_bus  in  32  raw IBUS read data
//     ba      out 4   byte-lane enables, bit3 = lane [31:24]
//     wd_rep  out 32  write data replicated across lanes
//     rd_just out 32  selected read lane, right-justified, zero-extended
module sh7604_ibus_lane
  import sh7604_ibus_master_pkg::*;
(
  input  logic [1:0]  sz,
  input  logic [1:0]  a_lo,
  input  logic [31:0] wd,
  input  logic [31:0] rd_bus,
  output logic [3:0]  ba,
  output logic [31:0] wd_rep,
  output logic [31:0] rd_just
);

  always_comb begin
    ba      = 4'b1111;
    wd_rep  = wd;
    rd_just = rd_bus;
    if (sz == SZ_B) begin
      ba      = 4'b1000 >> a_lo;
      wd_rep  = {4{wd[7:0]}};
      // Big-endian: offset 0 lives in [31:24], so shift by (3 - a_lo) bytes.
      rd_just = {24'd0, 8'(rd_bus >> {~a_lo, 3'b000})};
    end else if (sz == SZ_W) begin
      ba      = a_lo[1] ? 4'b0011 : 4'b1100;
      wd_rep  = {2{wd[15:0]}};
      rd_just = {16'd0, (a_lo[1] ? rd_bus[15:0] : rd_bus[31:16])};
    end
  end

endmodule

// File: rtl/sh7604_ibus_master.sv
// sh7604_ibus_master
//   IBUS initiator for the SH7604 on-chip peripheral region FFFFFE00-FFFFFFFF.
//   Turns one CPU/DMAC access into a REQ/WAIT/HOLD cycle on the internal bus.
//   Optional macro SH7604_IBUS_TIMEOUT_EN adds a busy timeout with BERR pulse.
//   Ports:
//     CLK, RST_N (async low), CE_R (state advance enable), EN (freeze when low),
//     RES_N (sync soft reset)
//     CPU_A/CPU_DI/CPU_SZ/CPU_WE/CPU_REQ  access request side
//     CPU_DO/CPU_BUSY/BERR                access response side
//     IBUS_A/IBUS_DI/IBUS_BA/IBUS_WE/IBUS_REQ  bus outputs
//     IBUS_DO/IBUS_BUSY/IBUS_ACT               OR-ed peripheral returns
module sh7604_ibus_master
  import sh7604_ibus_master_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE_R,
  input  logic        EN,
  input  logic        RES_N,
  input  logic [31:0] CPU_A,
  input  logic [31:0] CPU_DI,
  input  logic [1:0]  CPU_SZ,
  input  logic        CPU_WE,
  input  logic        CPU_REQ,
  output logic [31:0] CPU_DO,
  output logic        CPU_BUSY,
  output logic        BERR,
  output logic [31:0] IBUS_A,
  output logic [31:0] IBUS_DI,
  output logic [3:0]  IBUS_BA,
  output logic        IBUS_WE,
  output logic        IBUS_REQ,
  input  logic [31:0] IBUS_DO,
  input  logic        IBUS_BUSY,
  input  logic        IBUS_ACT
);

  IBusState_t  state_q, state_d;
  logic [31:0] a_q, d_q, do_q;
  logic [1:0]  sz_q;
  logic        we_q;
  logic        adv, in_region, active;
  logic        ld, cap, abort, tmo_hit;
  logic [3:0]  ba;
  logic [31:0] wd_rep, rd_just;

  assign adv       = EN & CE_R;
  assign in_region = ibus_in_region(CPU_A);
  assign active    = (state_q != IDLE);

  // Lane logic works off the latched access so the bus stays stable
  // through HOLD even if the requester moves on.
  sh7604_ibus_lane u_lane (
    .sz      (sz_q),
    .a_lo    (a_q[1:0]),
    .wd      (d_q),
    .rd_bus  (IBUS_DO),
    .ba      (ba),
    .wd_rep  (wd_rep),
    .rd_just (rd_just)
  );

  always_comb begin
    state_d = state_q;
    ld      = 1'b0;
    cap     = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE: if (CPU_REQ && in_region) begin
              state_d = REQ;
              ld      = 1'b1;
            end
      // Peripheral raises busy on this edge, so it is not sampled here.
      REQ:  state_d = WAIT;
      WAIT: if (!IBUS_BUSY) begin
              state_d = HOLD;
              cap     = 1'b1;
            end else if (tmo_hit) begin
              state_d = HOLD;
              abort   = 1'b1;
            end
      HOLD: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      a_q     <= '0;
      d_q     <= '0;
      sz_q    <= '0;
      we_q    <= 1'b0;
      do_q    <= '0;
    end else if (!RES_N) begin
      state_q <= IDLE;
      a_q     <= '0;
      d_q     <= '0;
      sz_q    <= '0;
      we_q    <= 1'b0;
      do_q    <= '0;
    end else if (adv) begin
      state_q <= state_d;
      if (ld) begin
        a_q  <= CPU_A;
        d_q  <= CPU_DI;
        sz_q <= CPU_SZ;
        we_q <= CPU_WE;
      end
      // No selected peripheral reads back as all ones (open bus).
      if (cap && !we_q) do_q <= IBUS_ACT ? rd_just : 32'hFFFF_FFFF;
      if (abort)        do_q <= 32'hFFFF_FFFF;
    end
  end

`ifdef SH7604_IBUS_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic       berr_q;

  assign tmo_hit = (state_q == WAIT) && IBUS_BUSY && (cnt_q == 8'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q  <= '0;
      berr_q <= 1'b0;
    end else if (!RES_N) begin
      cnt_q  <= '0;
      berr_q <= 1'b0;
    end else if (adv) begin
      berr_q <= abort;
      if (ld)                                 cnt_q <= '0;
      else if (state_q == WAIT && IBUS_BUSY)  cnt_q <= cnt_q + 8'd1;
    end
  end

  assign BERR = berr_q;
`else
  assign tmo_hit = 1'b0;
  assign BERR    = 1'b0;
`endif

  // Outputs are gated by state so IDLE (and reset) always shows a quiet bus.
  assign IBUS_REQ = (state_q == REQ) || (state_q == WAIT);
  assign IBUS_A   = active ? a_q    : '0;
  assign IBUS_DI  = active ? wd_rep : '0;
  assign IBUS_BA  = active ? ba     : '0;
  assign IBUS_WE  = active & we_q;
  assign CPU_DO   = do_q;
  assign CPU_BUSY = active | (CPU_REQ & in_region);

endmodule

// File: tb/tb_sh7604_ibus_master.sv
// tb_sh7604_ibus_master
//   Directed, table-driven bench for sh7604_ibus_master plus hand sequences
//   for out-of-region, freeze, resets mid-access and busy timeout.
//   Honours SH7604_IBUS_TIMEOUT_EN for the stuck-busy sequence.
module tb_sh7604_ibus_master;

  logic        clk = 1'b0;
  logic        rst_n, ce_r, en, res_n;
  logic [31:0] cpu_a, cpu_di, cpu_do;
  logic [1:0]  cpu_sz;
  logic        cpu_we, cpu_req, cpu_busy, berr;
  logic [31:0] ibus_a, ibus_di, ibus_do;
  logic [3:0]  ibus_ba;
  logic        ibus_we, ibus_req, ibus_busy, ibus_act;

  always #5 clk = ~clk;

  sh7604_ibus_master #(.TIMEOUT_CYC(8)) dut (
    .CLK(clk), .RST_N(rst_n), .CE_R(ce_r), .EN(en), .RES_N(res_n),
    .CPU_A(cpu_a), .CPU_DI(cpu_di), .CPU_SZ(cpu_sz), .CPU_WE(cpu_we), .CPU_REQ(cpu_req),
    .CPU_DO(cpu_do), .CPU_BUSY(cpu_busy), .BERR(berr),
    .IBUS_A(ibus_a), .IBUS_DI(ibus_di), .IBUS_BA(ibus_ba), .IBUS_WE(ibus_we), .IBUS_REQ(ibus_req),
    .IBUS_DO(ibus_do), .IBUS_BUSY(ibus_busy), .IBUS_ACT(ibus_act)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] wtcnt = 8'h00;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  sz;
    logic        we;
    int          busy;
    logic [31:0] rdat;
    logic        act;
    logic [3:0]  ba;
    logic [31:0] di;
    logic [31:0] dout;
    int          reqn;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete access with a responder that holds busy for v.busy WAIT edges.
  task automatic run_vec(input string tag, input vec_t v);
    int k;
    int rq;
    cpu_a = v.a; cpu_di = v.d; cpu_sz = v.sz; cpu_we = v.we;
    ibus_do = v.rdat; ibus_act = v.act; ibus_busy = 1'b0;
    cpu_req = 1'b1;
    #1;
    chk({tag, " busy_on_req"}, cpu_busy, 1'b1);
    step();
    cpu_req = 1'b0;
    chk({tag, " ba"}, ibus_ba, v.ba);
    chk({tag, " di"}, ibus_di, v.di);
    chk({tag, " a"},  ibus_a,  v.a);
    k = 0; rq = 0;
    while (ibus_req && k < 100) begin
      ibus_busy = (k >= 1 && k <= v.busy);
      rq++;
      step();
      k++;
    end
    ibus_busy = 1'b0;
    chk({tag, " req_edges"}, rq, v.reqn);
    // HOLD: request dropped, address/strobe/lanes still driven.
    chk({tag, " hold_ctl"}, {ibus_req, ibus_we, ibus_ba, cpu_busy}, {1'b0, v.we, v.ba, 1'b1});
    chk({tag, " hold_a"}, ibus_a, v.a);
    if (ibus_we && ibus_a == 32'hFFFF_FE80 && ibus_ba == 4'b1100 && ibus_di[31:24] == 8'h5A)
      wtcnt = ibus_di[23:16];
    step();
    chk({tag, " idle_bus"}, {ibus_a | ibus_di}, 32'h0);
    chk({tag, " idle_ctl"}, {ibus_ba, ibus_we, ibus_req, cpu_busy}, 7'h0);
    if (!v.we) chk({tag, " cpu_do"}, cpu_do, v.dout);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    //          a              d              sz     we    busy rdat           act   ba       di             dout           reqn
    vt[0] = '{32'hFFFF_FE80, 32'h0000_0000, 2'b10, 1'b0, 2, 32'hA5A5_1818, 1'b1, 4'b1111, 32'h0000_0000, 32'hA5A5_1818, 4};
    vt[1] = '{32'hFFFF_FE80, 32'h0000_5A37, 2'b01, 1'b1, 0, 32'h0000_0000, 1'b1, 4'b1100, 32'h5A37_5A37, 32'h0000_0000, 2};
    vt[2] = '{32'hFFFF_FE83, 32'h0000_0000, 2'b00, 1'b0, 0, 32'h0000_0019, 1'b1, 4'b0001, 32'h0000_0000, 32'h0000_0019, 2};
    vt[3] = '{32'hFFFF_FE81, 32'h0000_0000, 2'b00, 1'b0, 0, 32'h552A_6677, 1'b1, 4'b0100, 32'h0000_0000, 32'h0000_002A, 2};
    vt[4] = '{32'hFFFF_FE50, 32'h0000_0000, 2'b10, 1'b0, 0, 32'h1357_2468, 1'b0, 4'b1111, 32'h0000_0000, 32'hFFFF_FFFF, 2};
    vt[5] = '{32'hFFFF_FE92, 32'h0000_0000, 2'b01, 1'b0, 1, 32'h1234_ABCD, 1'b1, 4'b0011, 32'h0000_0000, 32'h0000_ABCD, 3};
    vt[6] = '{32'hFFFF_FE11, 32'hFFFF_00C3, 2'b00, 1'b1, 0, 32'h0000_0000, 1'b1, 4'b0100, 32'hC3C3_C3C3, 32'h0000_0000, 2};
    vt[7] = '{32'hFFFF_FE03, 32'h0000_0000, 2'b11, 1'b0, 0, 32'hDEAD_BEEF, 1'b1, 4'b1111, 32'h0000_0000, 32'hDEAD_BEEF, 2};
    vt[8] = '{32'hFFFF_FE81, 32'h0000_0000, 2'b01, 1'b0, 0, 32'h1234_ABCD, 1'b1, 4'b1100, 32'h0000_0000, 32'h0000_1234, 2};
    vt[9] = '{32'hFFFF_FFFC, 32'h1122_3344, 2'b10, 1'b1, 1, 32'h0000_0000, 1'b1, 4'b1111, 32'h1122_3344, 32'h0000_0000, 3};

    rst_n = 1'b0; res_n = 1'b1; ce_r = 1'b1; en = 1'b1;
    cpu_a = '0; cpu_di = '0; cpu_sz = '0; cpu_we = 1'b0; cpu_req = 1'b0;
    ibus_do = '0; ibus_busy = 1'b0; ibus_act = 1'b1;
    step(); step();
    chk("reset ctl", {ibus_req, ibus_we, ibus_ba, cpu_busy, berr}, 8'h0);
    chk("reset a", ibus_a, 32'h0);
    chk("reset di", ibus_di, 32'h0);
    chk("reset do", cpu_do, 32'h0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 10; i++) run_vec($sformatf("v%0d", i), vt[i]);
    chk("wtcnt commit", wtcnt, 8'h37);

    // Out-of-region requests are ignored, including just below the window.
    cpu_a = 32'h0600_0000; cpu_sz = 2'b10; cpu_we = 1'b0; cpu_req = 1'b1;
    #1;
    chk("oor busy", cpu_busy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("oor req%0d", i), {ibus_req, cpu_busy}, 2'b00);
    end
    cpu_a = 32'hFFFF_FDFF;
    #1;
    chk("below_window busy", cpu_busy, 1'b0);
    step();
    chk("below_window req", ibus_req, 1'b0);
    cpu_req = 1'b0;

    // EN / CE_R low freeze the FSM.
    cpu_a = 32'hFFFF_FE40; cpu_sz = 2'b10; ibus_do = 32'h0BAD_F00D; ibus_act = 1'b1;
    en = 1'b0; cpu_req = 1'b1;
    step(); step();
    chk("en_low no_req", {ibus_req, cpu_busy}, 2'b01);
    chk("en_low a", ibus_a, 32'h0);
    en = 1'b1; ce_r = 1'b0;
    step();
    chk("ce_low no_req", ibus_req, 1'b0);
    ce_r = 1'b1;
    step();
    cpu_req = 1'b0;
    chk("accept after freeze", ibus_req, 1'b1);
    en = 1'b0;
    step(); step();
    chk("frozen in req", {ibus_req, cpu_busy}, 2'b11);
    en = 1'b1;
    step(); step(); step();
    chk("freeze done busy", cpu_busy, 1'b0);
    chk("freeze done do", cpu_do, 32'h0BAD_F00D);

    // Async reset while in WAIT.
    cpu_a = 32'hFFFF_FE80; cpu_sz = 2'b10; cpu_req = 1'b1;
    step();
    cpu_req = 1'b0; ibus_busy = 1'b1;
    step(); step();
    chk("pre_rst req", ibus_req, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_wait req", {ibus_req, cpu_busy}, 2'b00);
    chk("rst_wait do", cpu_do, 32'h0);
    step();
    rst_n = 1'b1; ibus_busy = 1'b0;
    step();
    run_vec("post_rst", vt[2]);

    // Synchronous soft reset while in WAIT.
    cpu_a = 32'hFFFF_FE80; cpu_sz = 2'b10; cpu_req = 1'b1;
    step();
    cpu_req = 1'b0; ibus_busy = 1'b1;
    step(); step();
    res_n = 1'b0;
    #1;
    chk("res_n before edge", ibus_req, 1'b1);
    step();
    chk("res_n after edge", {ibus_req, cpu_busy}, 2'b00);
    res_n = 1'b1; ibus_busy = 1'b0;
    step();

    // Stuck busy.
    cpu_a = 32'hFFFF_FE10; cpu_sz = 2'b10; cpu_we = 1'b0;
    ibus_do = 32'h1234_5678; ibus_act = 1'b1; cpu_req = 1'b1;
    step();
    cpu_req = 1'b0; ibus_busy = 1'b1;
    step();
`ifdef SH7604_IBUS_TIMEOUT_EN
    for (int w = 1; w <= 8; w++) begin
      step();
      if (w == 7) chk("tmo 7th", {ibus_req, berr}, 2'b10);
    end
    chk("tmo 8th ctl", {ibus_req, berr, cpu_busy}, 3'b011);
    chk("tmo do", cpu_do, 32'hFFFF_FFFF);
    step();
    chk("tmo pulse end", {berr, cpu_busy}, 2'b00);
    ibus_busy = 1'b0;
`else
    repeat (20) step();
    chk("stall ctl", {ibus_req, cpu_busy, berr}, 3'b110);
    ibus_busy = 1'b0;
    step(); step();
    chk("stall release busy", cpu_busy, 1'b0);
    chk("stall release do", cpu_do, 32'h1234_5678);
`endif
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
